// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants and types for the datapath ALU adder blocks.
//   DATA_W  : operand/result width (the adder is built for 16 only)
//   GRP_W   : bits per first-level lookahead group
//   NUM_GRP : number of lookahead groups
//   word_t  : one datapath word
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W  = 16;
    localparam int GRP_W   = 4;
    localparam int NUM_GRP = DATA_W / GRP_W;

    typedef logic [DATA_W-1:0] word_t;

endpackage : alu_pkg

// File: rtl/cla_4bit.sv
// ---------------------------------------------------------------------------
// cla_4bit
// First-level 4-bit carry-lookahead group. It produces its own sum bits from
// the group carry-in and exports group generate/propagate to the second-level
// lookahead in the parent.
// Ports:
//   a, b : 4-bit operand slices
//   cin  : carry into bit 0 of this group
//   s    : 4-bit sum slice
//   gg   : group generate  (group produces a carry on its own)
//   gp   : group propagate (group passes cin straight through)
// ---------------------------------------------------------------------------
module cla_4bit
    import alu_pkg::*;
(
    input  logic [GRP_W-1:0] a,
    input  logic [GRP_W-1:0] b,
    input  logic             cin,
    output logic [GRP_W-1:0] s,
    output logic             gg,
    output logic             gp
);

    logic [GRP_W-1:0] w_g;
    logic [GRP_W-1:0] w_p;
    logic [GRP_W-1:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Every internal carry is a flat sum of products of cin, never a ripple
    // from the carry below it.
    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);

    assign s  = w_p ^ w_c;

    assign gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign gp = &w_p;

endmodule : cla_4bit

// File: rtl/cla_16bit.sv
// ---------------------------------------------------------------------------
// cla_16bit
// 16-bit two-level carry-lookahead adder: Sum = A + B + Cin with carry-out
// and signed overflow, plus a one-cycle registered copy of all three.
// Ports:
//   clk    : rising-edge clock for the output register
//   rst_n  : asynchronous active-low reset of the registered outputs only
//   A, B   : operands (two's complement or unsigned)
//   Cin    : carry into bit 0
//   Sum    : combinational sum, wraps modulo 2^16
//   Cout   : combinational carry-out (bit 16 of A+B+Cin)
//   Ovfl   : combinational signed overflow
//   Sum_q, Cout_q, Ovfl_q : the above, registered on every rising clk
// ---------------------------------------------------------------------------
module cla_16bit
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovfl,
    output logic [WIDTH-1:0] Sum_q,
    output logic             Cout_q,
    output logic             Ovfl_q
);

    logic [NUM_GRP-1:0] w_gg;
    logic [NUM_GRP-1:0] w_gp;
    logic [NUM_GRP:0]   w_gc;   // w_gc[k] = carry into group k; w_gc[4] = c16
    word_t              w_sum;

    // First level: four independent 4-bit lookahead groups.
    for (genvar k = 0; k < NUM_GRP; k++) begin : g_grp
        cla_4bit u_grp (
            .a   (A[k*GRP_W +: GRP_W]),
            .b   (B[k*GRP_W +: GRP_W]),
            .cin (w_gc[k]),
            .s   (w_sum[k*GRP_W +: GRP_W]),
            .gg  (w_gg[k]),
            .gp  (w_gp[k])
        );
    end

    // Second level: group carries c4/c8/c12/c16 expanded directly from Cin
    // and the group GG/GP terms, so no carry ripples from group to group.
    assign w_gc[0] = Cin;
    assign w_gc[1] = w_gg[0] | (w_gp[0] & Cin);
    assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & Cin);
    assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[2] & w_gp[1] & w_gp[0] & Cin);
    assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & Cin);

    assign Sum  = w_sum;
    assign Cout = w_gc[4];
    // Overflow: operands agree in sign but the result sign differs.
    assign Ovfl = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value; only these output flops are reset, the adder itself is
    // pure logic and stays live while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sum_q  <= '0;
            Cout_q <= 1'b0;
            Ovfl_q <= 1'b0;
        end else begin
            Sum_q  <= Sum;
            Cout_q <= Cout;
            Ovfl_q <= Ovfl;
        end
    end

endmodule : cla_16bit

// File: tb/tb_cla_16bit.sv
// ---------------------------------------------------------------------------
// tb_cla_16bit
// Self-checking bench for cla_16bit. Expected results are computed from the
// arithmetic definition, queued when stimulus is applied and popped when the
// corresponding DUT output is sampled.
// ---------------------------------------------------------------------------
module tb_cla_16bit;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovfl;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovfl;
    logic [15:0] sum_q;
    logic        cout_q;
    logic        ovfl_q;

    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    cla_16bit #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (a),
        .B      (b),
        .Cin    (cin),
        .Sum    (sum),
        .Cout   (cout),
        .Ovfl   (ovfl),
        .Sum_q  (sum_q),
        .Cout_q (cout_q),
        .Ovfl_q (ovfl_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference model straight from the arithmetic definition.
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mc);
        exp_t        e;
        logic [16:0] full;
        full   = {1'b0, ma} + {1'b0, mb} + {16'b0, mc};
        e.sum  = full[15:0];
        e.cout = full[16];
        e.ovfl = (ma[15] == mb[15]) && (full[15] != ma[15]);
        return e;
    endfunction

    task automatic drive(input logic [15:0] va, input logic [15:0] vb, input logic vc);
        a   = va;
        b   = vb;
        cin = vc;
        sb.push_back(model(va, vb, vc));
    endtask

    task automatic check_comb(input string tag, input exp_t e);
        check({tag, ".sum"},  32'(sum),  32'(e.sum));
        check({tag, ".cout"}, 32'(cout), 32'(e.cout));
        check({tag, ".ovfl"}, 32'(ovfl), 32'(e.ovfl));
        check({tag, ".inv"},  32'(cout && !a[15] && !b[15]), 32'(0));
    endtask

    // Directed vector: combinational check mid-cycle, registered check just
    // after the following rising edge.
    task automatic directed(input string tag, input logic [15:0] va,
                            input logic [15:0] vb, input logic vc);
        exp_t e;
        @(negedge clk);
        drive(va, vb, vc);
        #2;
        check_comb(tag, sb[0]);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".sum_q"},  32'(sum_q),  32'(e.sum));
        check({tag, ".cout_q"}, 32'(cout_q), 32'(e.cout));
        check({tag, ".ovfl_q"}, 32'(ovfl_q), 32'(e.ovfl));
    endtask

    initial begin
        exp_t e;
        int   fail_before;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        a        = 16'h0000;
        b        = 16'h0000;
        cin      = 1'b0;

        // Reset state, held across a rising edge.
        @(posedge clk);
        #1;
        check("rst.sum_q",  32'(sum_q),  32'(0));
        check("rst.cout_q", 32'(cout_q), 32'(0));
        check("rst.ovfl_q", 32'(ovfl_q), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        directed("inc",    16'h0001, 16'h0001, 1'b0);
        directed("chain",  16'hFFFF, 16'h0000, 1'b1);
        directed("ovpos",  16'h7FFF, 16'h0001, 1'b0);
        directed("ovneg",  16'h8000, 16'h8000, 1'b0);
        directed("grp4",   16'h000F, 16'h0001, 1'b0);
        directed("grp8",   16'h00FF, 16'h0001, 1'b0);
        directed("grp12",  16'h0FFF, 16'h0001, 1'b0);
        directed("cinall", 16'hAAAA, 16'h5555, 1'b1);

        // Asynchronous reset asserted between edges.
        directed("preld",  16'h1234, 16'h1111, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.sum_q",  32'(sum_q),  32'(0));
        check("arst.cout_q", 32'(cout_q), 32'(0));
        check("arst.ovfl_q", 32'(ovfl_q), 32'(0));
        check("arst.sum",    32'(sum),    32'(16'h2345));
        @(posedge clk);
        #1;
        check("arst.hold",   32'(sum_q),  32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        directed("postrst", 16'h4000, 16'h4000, 1'b0);

        // Random combinational sweep, stopping at the first mismatch.
        for (int i = 0; i < 65535; i++) begin
            fail_before = n_fail;
            drive(16'($urandom), 16'($urandom), 1'($urandom));
            #5;
            e = sb.pop_front();
            check_comb("rnd", e);
            if (n_fail != fail_before) begin
                $display("FAIL rnd: stopped at vector %0d (A=%h B=%h Cin=%b)", i, a, b, cin);
                break;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cla_16bit

// File: doc/cla_16bit.md
Name: cla_16bit

Overview:
- 16-bit two-level carry-lookahead adder for the datapath ALU: Sum = A + B + Cin, with carry-out and signed-overflow flag.
- Combinational result path, checked after a settle delay with no clock edge required.
- Registered copy of the result for pipelined consumers.
- One clock; reset is asynchronous and active-low.

Parameters:
- WIDTH, 16, operand/result width; the architecture is fixed at 4 groups of 4 bits, and only 16 is supported.

Ports:
- clk  input  1  rising-edge clock for the output register stage
- rst_n  input  1  asynchronous active-low reset of the registered outputs
- A  input  16  operand A (two's complement or unsigned)
- B  input  16  operand B
- Cin  input  1  carry-in into bit 0
- Sum  output  16  combinational sum bits [15:0] of A+B+Cin
- Cout  output  1  combinational carry-out, bit 16 of the 17-bit unsigned sum A+B+Cin
- Ovfl  output  1  combinational signed overflow: (A[15]==B[15]) && (Sum[15]!=A[15])
- Sum_q  output  16  Sum registered on the rising clk edge
- Cout_q  output  1  Cout registered
- Ovfl_q  output  1  Ovfl registered

Behaviour:
- Combinational path:
  - {Cout,Sum} equals the 17-bit zero-extended A + B + Cin for every input combination.
  - No saturation; the sum wraps modulo 2^16.
  - Sum, Cout and Ovfl depend only on A, B and Cin, with no dependence on clk or rst_n.
- Structure:
  - Bit level: generate g[i] = A[i]&B[i], propagate p[i] = A[i]^B[i].
  - Each 4-bit group computes its internal carries by lookahead from its group carry-in.
  - Each group produces group generate GG = g3 | p3g2 | p3p2g1 | p3p2p1g0 and group propagate GP = p3&p2&p1&p0.
  - Second-level lookahead computes group carries c4, c8, c12 and c16 from the GG/GP signals and Cin. No ripple between groups.
  - Sum[i] = p[i] ^ c[i]; Cout = c16.
- Overflow:
  - Ovfl is reported for both signed and unsigned use; consumers ignore it when unsigned.
  - Cout && !A[15] && !B[15] cannot occur. A bench asserts this never happens.
- Registered path:
  - Latency is 1 cycle: on each rising clk, Sum_q<=Sum, Cout_q<=Cout, Ovfl_q<=Ovfl.
  - There is no enable; the register loads every cycle.
- Reset:
  - rst_n low asynchronously forces Sum_q=16'h0000, Cout_q=0, Ovfl_q=0, including when asserted mid-cycle.
  - These values hold while rst_n is low.
  - The first capture happens on the first rising clk after rst_n deasserts.
  - The combinational outputs stay live during reset.
- X-handling: if any input bit is X, the outputs may be X. There is no masking.

Decomposition:
- Shared package (alu_pkg) holds:
  - localparam DATA_W = 16;
  - localparam GRP_W = 4;
  - typedef logic [DATA_W-1:0] word_t.
- One sub-module, cla_4bit. Inputs: a[3:0], b[3:0], cin. Outputs: s[3:0], gg, gp.
- The top instantiates 4 copies, plus an inline second-level carry unit and the output register.

Test Plan:
- A=16'h0001, B=16'h0001, Cin=0 -> Sum=16'h0002, Cout=0, Ovfl=0; Sum_q=16'h0002 after one clk.
- A=16'hFFFF, B=16'h0000, Cin=1 -> Sum=16'h0000, Cout=1, Ovfl=0. This is the full-length propagate chain through all group lookahead.
- A=16'h7FFF, B=16'h0001, Cin=0 -> Sum=16'h8000, Cout=0, Ovfl=1. A=16'h8000, B=16'h8000, Cin=0 -> Sum=16'h0000, Cout=1, Ovfl=1.
- Group-boundary carries:
  - A=16'h000F, B=16'h0001 -> 16'h0010.
  - A=16'h00FF, B=16'h0001 -> 16'h0100.
  - A=16'h0FFF, B=16'h0001 -> 16'h1000.
  - All with Cout=0.
- Reset: load A=16'h1234, B=16'h1111 and clock, so Sum_q=16'h2345. Assert rst_n=0 between edges -> Sum_q, Cout_q and Ovfl_q go to 0 immediately, while Sum stays 16'h2345.
- Random: 65535 vectors of random A, B and Cin, each checked 5 time units after application.
  - Require {Cout,Sum} == 17-bit A+B+Cin, and Ovfl matching the formula.
  - Require that no vector has Cout=1 with both A[15] and B[15] zero.
  - Stop on the first mismatch.
